// File: rtl/timer_count_ctrl.sv
// Timer counter sequencer: decodes TCR, runs the prescaler and
// loads, increments or decrements TCNT with overflow/underflow pulses.
module timer_count_ctrl #(
    parameter int CNT_WIDTH = 8,
    parameter int PSC_WIDTH = 4
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [CNT_WIDTH-1:0] TDR,
    input  logic [7:0]           TCR,
    output logic [CNT_WIDTH-1:0] TCNT,
    output logic                 TMR_OVF,
    output logic                 TMR_UDF,
    output logic                 CNT_ACTIVE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic [PSC_WIDTH-1:0] div_m1;
    logic [1:0]           cks_q;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 act_q;
    logic                 tick;
    logic                 cks_chg;

    logic                 tcr_load, tcr_dir, tcr_en;
    logic [1:0]           tcr_cks;
    logic                 unused_tcr;

    assign tcr_load   = TCR[7];
    assign tcr_dir    = TCR[5];
    assign tcr_en     = TCR[4];
    assign tcr_cks    = TCR[1:0];
    assign unused_tcr = ^{TCR[6], TCR[3:2]};

    always_comb begin
        div_m1 = PSC_WIDTH'(1);
        case (tcr_cks)
            2'b00:   div_m1 = PSC_WIDTH'(1);
            2'b01:   div_m1 = PSC_WIDTH'(3);
            2'b10:   div_m1 = PSC_WIDTH'(7);
            default: div_m1 = PSC_WIDTH'(15);
        endcase
    end

    // A divide change only restarts the prescaler once already counting.
    assign cks_chg = (state_q == COUNT) && (tcr_cks != cks_q);

    always_comb begin
        state_d = IDLE;
        if (tcr_load) begin
            state_d = LOAD;
        end else if (tcr_en) begin
            state_d = COUNT;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        psc_d = '0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        tick  = 1'b0;
        if (state_d == LOAD) begin
            cnt_d = TDR;
        end else if (state_d == COUNT) begin
            if (cks_chg) begin
                psc_d = '0;
            end else if (psc_q == div_m1) begin
                psc_d = '0;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q + PSC_WIDTH'(1);
            end
        end
        if (tick) begin
            if (tcr_dir) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                udf_d = (cnt_q == '0);
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                ovf_d = &cnt_q;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            psc_q   <= '0;
            cks_q   <= 2'b00;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            psc_q   <= psc_d;
            cks_q   <= tcr_cks;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            act_q   <= (state_d == COUNT);
        end
    end

    assign TCNT       = cnt_q;
    assign TMR_OVF    = ovf_q;
    assign TMR_UDF    = udf_q;
    assign CNT_ACTIVE = act_q;

endmodule

// File: doc/timer_count_ctrl.md
Name: timer_count_ctrl

Overview:
Sequencing controller for the 8-bit timer counter datapath. It decodes the control register (TCR) and data register (TDR) supplied by the APB register block, runs a programmable prescaler, and loads, counts up or counts down TCNT. It generates the one-cycle TMR_OVF/TMR_UDF event pulses that the register block latches into TSR. It sits between the register-control block and the rest of the timer.

Parameters:
CNT_WIDTH, 8, width of TCNT and TDR
PSC_WIDTH, 4, prescaler counter width (must hold max divide-1 = 15)

Ports:
PCLK  input  1  system clock; all logic on rising edge
PRESET  input  1  synchronous reset, active-high
TDR  input  CNT_WIDTH  reload value from register block
TCR  input  8  control: [7]=LOAD, [5]=DIR (0 up, 1 down), [4]=EN, [1:0]=CKS; other bits ignored
TCNT  output  CNT_WIDTH  current counter value (to register block read path)
TMR_OVF  output  1  one-cycle overflow pulse
TMR_UDF  output  1  one-cycle underflow pulse
CNT_ACTIVE  output  1  high while FSM is in COUNT

Behaviour:
- Interface: single clock PCLK; reset PRESET is synchronous and active-high. All outputs are registered.
- Reset (PRESET=1 at an edge): TCNT=0x00, TMR_OVF=0, TMR_UDF=0, CNT_ACTIVE=0, prescaler=0, state=IDLE. Reset wins over everything, including mid-count and mid-load.
- Prescale divide: CKS 00 -> /2, 01 -> /4, 10 -> /8, 11 -> /16.
- FSM states: IDLE, LOAD, COUNT. The next state is evaluated every edge from the sampled TCR, with priority LOAD > EN:
  - TCR[7]=1 -> LOAD.
  - else TCR[4]=1 -> COUNT.
  - else -> IDLE.
- IDLE: TCNT holds; prescaler cleared to 0; no pulses.
- LOAD: TCNT <= TDR on every edge while in LOAD, tracking TDR changes. Prescaler cleared; no pulses; CNT_ACTIVE=0.
- COUNT: CNT_ACTIVE=1.
  - Prescaler increments each edge. When prescaler == divide-1, it wraps to 0 and a tick occurs on that edge.
  - Tick with DIR=0: TCNT <= TCNT+1 (modulo 2^CNT_WIDTH).
  - Tick with DIR=1: TCNT <= TCNT-1 (modulo 2^CNT_WIDTH).
- Latency: the first tick lands on the divide-th edge after the first edge at which COUNT is entered. Example /2: entry edge N sets prescaler 0->1; edge N+1 ticks.
- Overflow: tick with DIR=0 and TCNT==all-ones -> TCNT=0x00 and TMR_OVF=1 on the same edge, for exactly one cycle.
- Underflow: tick with DIR=1 and TCNT==0x00 -> TCNT=all-ones and TMR_UDF=1 on the same edge, for exactly one cycle.
- OVF and UDF are never both 1. Both are 0 in every non-tick cycle.
- CKS change while in COUNT: a registered copy of CKS is kept. On any edge where the sampled CKS differs from that copy, the prescaler clears to 0 and no tick occurs. Counting resumes with the new divide.
- DIR change mid-count takes effect at the next tick; the prescaler is not cleared.
- EN dropped mid-count: go to IDLE, TCNT frozen, prescaler lost. Re-enable restarts the full divide period.
- LOAD asserted while EN=1: load has priority. After LOAD clears with EN=1, counting starts from TDR with a fresh prescaler.
- Overflow and LOAD on the same edge: LOAD wins; no pulse.
- Reserved TCR bits have no effect.

Test Plan:
1. Reset: drive PRESET=1 for 2 cycles with TCR=0x90 -> TCNT=0x00, TMR_OVF=0, TMR_UDF=0, CNT_ACTIVE=0; after release TCNT=TDR on the next edge.
2. Load then count up /2: TDR=0xFD, TCR=0x80 for 1 cycle, then TCR=0x10 -> TCNT goes 0xFD, 0xFE, 0xFF, 0x00 at 2-cycle spacing; TMR_OVF=1 for exactly the one cycle where TCNT becomes 0x00.
3. Count down /16: TDR=0x01, load, then TCR=0x33 -> TCNT=0x00 after 16 cycles, then 0xFF with a single-cycle TMR_UDF after 16 more; TMR_OVF stays 0.
4. CKS switch mid-count: counting /8 with prescaler at 5, change TCR[1:0] 10->00 -> no tick on the change edge; the next tick comes 2 cycles later.
5. Pause/resume and priority:
   - Counting up, drop EN for 10 cycles -> TCNT frozen, CNT_ACTIVE=0; re-enable with /4 -> next increment after 4 cycles.
   - Assert TCR=0x90 with TCNT=0xFF on a tick edge -> TCNT=TDR, no TMR_OVF.
6. Reset mid-count: PRESET=1 on an edge where a tick is due -> TCNT=0x00, no pulse, state IDLE.
